// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU pipeline: default data/address
// widths, the 4-bit opcode map and the bit positions of the Z/N/C/V flags
// inside the 4-bit flag vector.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int OPC_W          = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h5;
    localparam logic [OPC_W-1:0] OP_NOT = 4'h6;
    localparam logic [OPC_W-1:0] OP_SHL = 4'h7;
    localparam logic [OPC_W-1:0] OP_SHR = 4'h8;
    localparam logic [OPC_W-1:0] OP_ADC = 4'h9;
    localparam logic [OPC_W-1:0] OP_SBB = 4'hA;
    localparam logic [OPC_W-1:0] OP_MOV = 4'hB;
    localparam logic [OPC_W-1:0] OP_CMP = 4'hC;
    localparam logic [OPC_W-1:0] OP_MUL = 4'hD;
    localparam logic [OPC_W-1:0] OP_INC = 4'hE;
    localparam logic [OPC_W-1:0] OP_DEC = 4'hF;

    // Flag vector layout is {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mul8_seq.sv
// ---------------------------------------------------------------------------
// mul8_seq
// Sequential shift-add multiplier. A start pulse loads the operands; each
// following cycle performs one shift-add step. On the final step o_done is
// high and o_product carries the full product that the step is about to
// register, so the caller can capture it on that same edge.
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset    asynchronous active-low reset
//   i_start    load operands and begin (ignored semantics while busy are the
//              caller's responsibility)
//   i_a, i_b   multiplicand / multiplier
//   o_done     high during the cycle whose edge completes the last step
//   o_product  2*DATA_W-bit product, valid while o_done is high
// ---------------------------------------------------------------------------
module mul8_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic                o_done,
    output logic [2*DATA_W-1:0] o_product
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [2*DATA_W-1:0] acc_q,   acc_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                busy_q,  busy_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (i_start) begin
            mcand_d  = {{DATA_W{1'b0}}, i_a};
            mplier_d = i_b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            // Add the shifted multiplicand for each set multiplier bit, LSB first
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign o_done    = busy_q && (cnt_q == CNT_LAST);
    assign o_product = acc_d;

endmodule

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// Execute stage of the 8-bit CPU pipeline. Computes the ALU result and
// Z/N/C/V flags for the incoming opcode and registers a write-back request
// for the register bank. MUL runs on the sequential multiplier and stalls
// upstream for its duration.
//
// Ports:
//   i_clk, i_reset      clock (rising edge), async active-low reset
//   i_opcode            operation, 0 = NOP/bubble
//   i_destadd           destination register (r0 is never written)
//   i_read_data1/2      operands A / B
//   o_write_en          one-cycle write-back strobe
//   o_write_reg/data    write-back register / data
//   o_flags             registered {Z,N,C,V}
//   o_stall             registered, high while a MUL is in progress
// ---------------------------------------------------------------------------
module execute_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [3:0]        i_opcode,
    input  logic [ADDR_W-1:0] i_destadd,
    input  logic [DATA_W-1:0] i_read_data1,
    input  logic [DATA_W-1:0] i_read_data2,
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_write_reg,
    output logic [DATA_W-1:0] o_write_data,
    output logic [3:0]        o_flags,
    output logic              o_stall
);

    localparam int MSB = DATA_W - 1;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

    logic [0:0]        state_q,      state_d;
    logic [ADDR_W-1:0] mul_dest_q,   mul_dest_d;
    logic              write_en_q,   write_en_d;
    logic [ADDR_W-1:0] write_reg_q,  write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [3:0]        flags_q,      flags_d;
    logic              stall_q,      stall_d;

    // ---------------- ALU ----------------
    logic [DATA_W-1:0] a, b;
    logic [DATA_W-1:0] arith_b;
    logic              arith_cin;
    logic [DATA_W:0]   sum, diff;
    logic              add_v, sub_v;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v;

    assign a = i_read_data1;
    assign b = i_read_data2;

    // INC/DEC reuse the adder/subtractor with B forced to 1; ADC/SBB feed
    // the currently registered carry in.
    always_comb begin
        arith_b   = ((i_opcode == OP_INC) || (i_opcode == OP_DEC)) ? DATA_W'(1) : b;
        arith_cin = ((i_opcode == OP_ADC) || (i_opcode == OP_SBB)) ? flags_q[FLAG_C] : 1'b0;
    end

    assign sum   = {1'b0, a} + {1'b0, arith_b} + {{DATA_W{1'b0}}, arith_cin};
    // Top bit of the widened difference is the borrow (A < B + cin)
    assign diff  = {1'b0, a} - {1'b0, arith_b} - {{DATA_W{1'b0}}, arith_cin};
    assign add_v = (a[MSB] == arith_b[MSB]) && (sum[MSB]  != a[MSB]);
    assign sub_v = (a[MSB] != arith_b[MSB]) && (diff[MSB] != a[MSB]);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (i_opcode)
            OP_ADD, OP_ADC, OP_INC: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[DATA_W];
                alu_v   = add_v;
            end
            OP_SUB, OP_SBB, OP_CMP, OP_DEC: begin
                alu_res = diff[MSB:0];
                alu_c   = diff[DATA_W];
                alu_v   = sub_v;
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_MOV: alu_res = b;
            OP_SHL: begin
                alu_res = a << 1;
                alu_c   = a[MSB];
            end
            OP_SHR: begin
                alu_res = a >> 1;
                alu_c   = a[0];
            end
            default: begin
                alu_res = '0;
            end
        endcase
    end

    // ---------------- Multiplier ----------------
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;
    logic [DATA_W-1:0]   mul_lo, mul_hi;

    assign mul_start = (state_q == ST_IDLE) && (i_opcode == OP_MUL);
    assign mul_lo    = mul_product[DATA_W-1:0];
    assign mul_hi    = mul_product[2*DATA_W-1:DATA_W];

    mul8_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (mul_start),
        .i_a       (a),
        .i_b       (b),
        .o_done    (mul_done),
        .o_product (mul_product)
    );

    // ---------------- FSM / output registers ----------------
    always_comb begin
        state_d      = state_q;
        mul_dest_d   = mul_dest_q;
        write_en_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        flags_d      = flags_q;
        stall_d      = stall_q;
        case (state_q)
            ST_IDLE: begin
                if (i_opcode == OP_MUL) begin
                    state_d    = ST_MUL_BUSY;
                    mul_dest_d = i_destadd;
                    stall_d    = 1'b1;
                end else if (i_opcode != OP_NOP) begin
                    flags_d[FLAG_Z] = (alu_res == '0);
                    flags_d[FLAG_N] = alu_res[MSB];
                    flags_d[FLAG_C] = alu_c;
                    flags_d[FLAG_V] = alu_v;
                    if (i_opcode != OP_CMP) begin
                        write_reg_d  = i_destadd;
                        write_data_d = alu_res;
                        write_en_d   = (i_destadd != '0);
                    end
                end
            end
            ST_MUL_BUSY: begin
                // Upstream inputs are ignored until the last step completes
                if (mul_done) begin
                    state_d         = ST_IDLE;
                    stall_d         = 1'b0;
                    write_reg_d     = mul_dest_q;
                    write_data_d    = mul_lo;
                    write_en_d      = (mul_dest_q != '0);
                    flags_d[FLAG_Z] = (mul_lo == '0);
                    flags_d[FLAG_N] = mul_lo[MSB];
                    flags_d[FLAG_C] = (mul_hi != '0);
                    flags_d[FLAG_V] = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stall_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            mul_dest_q   <= '0;
            write_en_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            flags_q      <= '0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mul_dest_q   <= mul_dest_d;
            write_en_q   <= write_en_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            flags_q      <= flags_d;
            stall_q      <= stall_d;
        end
    end

    assign o_write_en   = write_en_q;
    assign o_write_reg  = write_reg_q;
    assign o_write_data = write_data_q;
    assign o_flags      = flags_q;
    assign o_stall      = stall_q;

endmodule
